// File: rtl/fpu_sequencer.sv
// fpu_sequencer: buffers FPU instructions in a small FIFO, issues them one at a
// time on the fpu ready/valid handshake and returns one tagged response each.
module fpu_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [5:0]               req_op,
  input  logic [4:0]               req_x1,
  input  logic [4:0]               req_x2,
  input  logic [4:0]               req_y,
  input  logic [31:0]              req_data,
  input  logic [3:0]               req_tag,
  output logic [4:0]               fpu_x1,
  output logic [4:0]               fpu_x2,
  output logic [4:0]               fpu_y,
  output logic [5:0]               fpu_op,
  output logic [31:0]              fpu_in_data,
  output logic                     fpu_ready,
  input  logic                     fpu_valid,
  input  logic [31:0]              fpu_out_data,
  input  logic                     fpu_cond,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_cond,
  output logic [3:0]               rsp_tag,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_FCLT = 6'b100000;
  localparam logic [5:0] OP_FCZ  = 6'b101000;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
    logic [3:0]  tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic legal;
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000101, 6'b000110,
      6'b010000, 6'b100000, 6'b101000, 6'b111000, 6'b111001,
      6'b111101, 6'b111110, 6'b111111: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_next;
  entry_t             head;
  logic               empty;
  logic               head_legal;
  logic               push_c;
  logic               pop_c;
  logic               rsp_load_c;
  logic               capture_c;
  logic [31:0]        data_hold;
  state_t             state;
  state_t             state_next;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign head_legal = op_legal(head.op);
  assign push_c     = req_valid && req_ready;

  // Operand outputs always mirror the FIFO head; only fpu_ready gates the fpu.
  assign fpu_op      = empty ? '0 : head.op;
  assign fpu_x1      = empty ? '0 : head.x1;
  assign fpu_x2      = empty ? '0 : head.x2;
  assign fpu_y       = empty ? '0 : head.y;
  assign fpu_in_data = empty ? '0 : head.data;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    rsp_load_c = 1'b0;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!rsp_valid || rsp_ready))
          state_next = head_legal ? ISSUE : DRAIN;
      end
      ISSUE: begin
        if (fpu_valid) begin
          capture_c  = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        pop_c      = 1'b1;
        rsp_load_c = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push_c && !pop_c)      count_next = count + CNT_W'(1);
    else if (!push_c && pop_c) count_next = count - CNT_W'(1);
  end

  // Pointers and occupancy; req_ready follows the registered occupancy, so no bypass.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      req_ready <= (count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= '{op: req_op, x1: req_x1, x2: req_x2, y: req_y,
                       data: req_data, tag: req_tag};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpu_ready <= 1'b0;
      data_hold <= '0;
    end else begin
      fpu_ready <= (state_next == ISSUE);
      if (capture_c) data_hold <= fpu_out_data;
    end
  end

  // Response holding registers; a reload in the same cycle wins over consumption.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cond  <= 1'b0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (rsp_load_c) begin
      rsp_valid <= 1'b1;
      rsp_tag   <= head.tag;
      rsp_err   <= !head_legal;
      rsp_data  <= head_legal ? data_hold : 32'h0;
      if ((head.op == OP_FCLT) || (head.op == OP_FCZ)) rsp_cond <= fpu_cond;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: behavioural fpu model, response monitor and
// hand-computed expectations checked with immediate assertions.
`timescale 1ns/1ps
module tb_fpu_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [5:0] OP_FMUL = 6'b000010;
  localparam logic [5:0] OP_FMOV = 6'b000110;
  localparam logic [5:0] OP_FCLT = 6'b100000;
  localparam logic [5:0] OP_FCZ  = 6'b101000;
  localparam logic [5:0] OP_FTOI = 6'b111000;
  localparam logic [5:0] OP_FORI = 6'b111101;
  localparam logic [5:0] OP_SET  = 6'b111110;
  localparam logic [5:0] OP_GET  = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b000111;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [5:0]       req_op = '0;
  logic [4:0]       req_x1 = '0;
  logic [4:0]       req_x2 = '0;
  logic [4:0]       req_y = '0;
  logic [31:0]      req_data = '0;
  logic [3:0]       req_tag = '0;
  logic [4:0]       fpu_x1, fpu_x2, fpu_y;
  logic [5:0]       fpu_op;
  logic [31:0]      fpu_in_data;
  logic             fpu_ready;
  logic             fpu_valid;
  logic [31:0]      fpu_out_data;
  logic             fpu_cond;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_data;
  logic             rsp_cond;
  logic [3:0]       rsp_tag;
  logic             rsp_err;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  fpu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_y(req_y),
    .req_data(req_data), .req_tag(req_tag),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y), .fpu_op(fpu_op),
    .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cond(rsp_cond), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .count(count)
  );

  // ---------------- fpu model ----------------
  function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31] && !((a[30:0] == 0) && (b[30:0] == 0));
    if (!a[31])         return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic logic [31:0] f2i(input logic [31:0] a);
    logic [31:0] mag;
    int e;
    e = int'(a[30:23]) - 127;
    if (e < 0)        mag = 32'h0;
    else if (e > 30)  mag = 32'h7fffffff;
    else if (e >= 23) mag = {8'h0, 1'b1, a[22:0]} << (e - 23);
    else              mag = {8'h0, 1'b1, a[22:0]} >> (23 - e);
    return a[31] ? -mag : mag;
  endfunction

  logic [31:0] rf [32];
  int unsigned m_cnt;
  int unsigned m_lat;
  logic        m_done;

  always_comb begin
    m_lat = 3;
    if (fpu_op == OP_FMOV || fpu_op == OP_FORI || fpu_op == OP_SET || fpu_op == OP_GET)
      m_lat = 1;
  end

  assign fpu_valid = fpu_ready && !m_done && (m_cnt == m_lat - 1);

  always_comb begin
    fpu_out_data = 32'h0;
    if (fpu_op == OP_GET)       fpu_out_data = rf[fpu_x1];
    else if (fpu_op == OP_FTOI) fpu_out_data = f2i(rf[fpu_x1]);
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      fpu_cond <= 1'b0;
    end else if (!fpu_ready) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (fpu_valid) begin
      m_done <= 1'b1;
      if (fpu_op == OP_SET)  rf[fpu_y] <= fpu_in_data;
      if (fpu_op == OP_FCLT) fpu_cond <= flt_lt(rf[fpu_x1], rf[fpu_x2]);
      if (fpu_op == OP_FCZ)  fpu_cond <= (rf[fpu_x1][30:0] == 31'h0);
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- monitor ----------------
  int   n_valid = 0;
  int   n_rav = 0;
  int   n_bad = 0;
  logic prev_valid = 1'b0;
  logic [3:0]  r_tag  [$];
  logic [31:0] r_data [$];
  logic        r_err  [$];
  logic        r_cond [$];

  always @(negedge clk) begin
    if (fpu_ready && prev_valid)          n_rav <= n_rav + 1;
    if (fpu_ready && fpu_op == OP_BAD)    n_bad <= n_bad + 1;
    if (fpu_valid)                        n_valid <= n_valid + 1;
    prev_valid <= fpu_valid;
    if (rsp_valid && rsp_ready) begin
      r_tag.push_back(rsp_tag);
      r_data.push_back(rsp_data);
      r_err.push_back(rsp_err);
      r_cond.push_back(rsp_cond);
    end
  end

  // ---------------- checking helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                      input logic [4:0] y, input logic [31:0] data, input logic [3:0] tag);
    int g;
    g = 0;
    while (!req_ready && g < 100) begin
      tick(1);
      g++;
    end
    chk("push_ready", 32'(req_ready), 32'd1);
    req_op = op; req_x1 = x1; req_x2 = x2; req_y = y; req_data = data; req_tag = tag;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int g;
    g = 0;
    while (r_tag.size() < n && g < 200) begin
      tick(1);
      g++;
    end
    chk("rsp_wait", 32'(r_tag.size() >= n), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},     32'(count),       32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready),   32'd1);
    chk({tag, "_fpu_ready"}, 32'(fpu_ready),   32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_data"},  rsp_data,         32'd0);
    chk({tag, "_rsp_cond"},  32'(rsp_cond),    32'd0);
    chk({tag, "_rsp_tag"},   32'(rsp_tag),     32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),     32'd0);
    chk({tag, "_fpu_ops"},   {fpu_op, fpu_x1, fpu_x2, fpu_y}, 32'd0);
    chk({tag, "_fpu_data"},  fpu_in_data,      32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int g;

    tick(3);
    chk_reset_outputs("reset");

    // single SET: ready only in cycle 2, response in cycle 4
    rstn = 1'b1;
    push(OP_SET, 5'd0, 5'd0, 5'd3, 32'h3F800000, 4'd1);
    chk("set_c1_count", 32'(count), 32'd1);
    chk("set_c1_ready", 32'(fpu_ready), 32'd0);
    tick(1);
    chk("set_c2_ready", 32'(fpu_ready), 32'd1);
    chk("set_c2_op",    32'(fpu_op), 32'(OP_SET));
    chk("set_c2_y",     32'(fpu_y), 32'd3);
    chk("set_c2_data",  fpu_in_data, 32'h3F800000);
    tick(1);
    chk("set_c3_ready", 32'(fpu_ready), 32'd0);
    chk("set_c3_rsp",   32'(rsp_valid), 32'd0);
    tick(1);
    chk("set_c4_rsp",   32'(rsp_valid), 32'd1);
    chk("set_c4_tag",   32'(rsp_tag), 32'd1);
    chk("set_c4_err",   32'(rsp_err), 32'd0);
    chk("set_c4_count", 32'(count), 32'd0);
    tick(1);
    chk("set_c5_rsp",   32'(rsp_valid), 32'd0);

    // FCLT both orderings
    base = r_tag.size();
    push(OP_SET,  5'd0, 5'd0, 5'd1, 32'h40000000, 4'd2);
    push(OP_SET,  5'd0, 5'd0, 5'd2, 32'h3F800000, 4'd3);
    push(OP_FCLT, 5'd2, 5'd1, 5'd0, 32'h0,        4'd4);
    wait_rsp(base + 3);
    chk("fclt1_tag",  32'(r_tag[base + 2]),  32'd4);
    chk("fclt1_cond", 32'(r_cond[base + 2]), 32'd1);
    chk("fclt1_err",  32'(r_err[base + 2]),  32'd0);
    push(OP_FCLT, 5'd1, 5'd2, 5'd0, 32'h0, 4'd5);
    wait_rsp(base + 4);
    chk("fclt2_tag",  32'(r_tag[base + 3]),  32'd5);
    chk("fclt2_cond", 32'(r_cond[base + 3]), 32'd0);

    // FTOI of pi, drain gap after the multi-cycle valid
    base = r_tag.size();
    push(OP_SET,  5'd0, 5'd0, 5'd1, 32'h40490FDB, 4'd6);
    push(OP_FTOI, 5'd1, 5'd0, 5'd0, 32'h0,        4'd7);
    g = 0;
    while (!(fpu_valid && fpu_op == OP_FTOI) && g < 100) begin
      tick(1);
      g++;
    end
    chk("ftoi_valid_seen", 32'(fpu_valid), 32'd1);
    tick(1);
    chk("ftoi_drain_ready", 32'(fpu_ready), 32'd0);
    chk("ftoi_drain_rsp",   32'(rsp_valid), 32'd0);
    tick(1);
    chk("ftoi_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ftoi_rsp_tag",   32'(rsp_tag),   32'd7);
    chk("ftoi_rsp_data",  rsp_data,       32'd3);
    wait_rsp(base + 2);
    chk("ftoi_q_data", r_data[base + 1], 32'd3);

    // backpressure: 5 pushes with response held
    base = r_tag.size();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(OP_SET, 5'd0, 5'd0, 5'(4 + i), 32'(i), 4'(10 + i));
    tick(3);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_tag",   32'(rsp_tag),   32'd10);
    chk("bp_count",     32'(count),     32'd4);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_fpu_ready", 32'(fpu_ready), 32'd0);
    chk("bp_no_rsp",    32'(r_tag.size()), 32'(base));
    rsp_ready = 1'b1;
    wait_rsp(base + 5);
    for (int i = 0; i < 5; i++)
      chk("bp_order", 32'(r_tag[base + i]), 32'(10 + i));
    tick(2);
    chk("bp_count_end", 32'(count), 32'd0);

    // illegal opcode between two GETs
    base = r_tag.size();
    push(OP_GET, 5'd3, 5'd0, 5'd0, 32'h0, 4'd8);
    push(OP_BAD, 5'd1, 5'd2, 5'd3, 32'h12345678, 4'd9);
    push(OP_GET, 5'd1, 5'd0, 5'd0, 32'h0, 4'd12);
    wait_rsp(base + 3);
    chk("get1_tag",  32'(r_tag[base]),     32'd8);
    chk("get1_data", r_data[base],         32'h3F800000);
    chk("get1_err",  32'(r_err[base]),     32'd0);
    chk("bad_tag",   32'(r_tag[base + 1]), 32'd9);
    chk("bad_err",   32'(r_err[base + 1]), 32'd1);
    chk("bad_data",  r_data[base + 1],     32'd0);
    chk("get2_tag",  32'(r_tag[base + 2]), 32'd12);
    chk("get2_data", r_data[base + 2],     32'h40490FDB);
    chk("get2_err",  32'(r_err[base + 2]), 32'd0);
    chk("bad_never_ready",   32'(n_bad),   32'd0);
    chk("ready_after_valid", 32'(n_rav),   32'd0);
    chk("valid_total",       32'(n_valid), 32'd14);

    // reset during FMUL issue
    base = r_tag.size();
    push(OP_FMUL, 5'd1, 5'd2, 5'd5, 32'h0, 4'd15);
    tick(1);
    chk("fmul_issue_ready", 32'(fpu_ready), 32'd1);
    chk("fmul_issue_op",    32'(fpu_op),    32'(OP_FMUL));
    rstn = 1'b0;
    tick(1);
    chk_reset_outputs("midreset");
    rstn = 1'b1;
    tick(8);
    chk("fmul_no_rsp",      32'(r_tag.size()), 32'(base));
    chk("fmul_rsp_valid",   32'(rsp_valid),    32'd0);
    chk("fmul_fpu_ready",   32'(fpu_ready),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Front-end controller between the core's FP issue stage and the `fpu` register-file datapath. It buffers FPU instructions in a DEPTH-entry FIFO and issues them one at a time on the fpu's level-sensitive `ready`/`valid` interface, holding operands stable until completion. It inserts the mandatory post-completion gap, captures `out_data`/`cond`, and returns one tagged response per instruction. Illegal opcodes complete locally with an error flag and are never presented to the fpu.

## Interface
- DEPTH, 4, instruction FIFO entries; power of two, ≥2
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  instruction offered
- req_ready  out  1  FIFO can accept, = !full
- req_op  in  6  fpu opcode
- req_x1, req_x2, req_y  in  5 each  source/dest register indices
- req_data  in  32  immediate / integer operand (in_data)
- req_tag  in  4  caller tag, returned in response
- fpu_x1, fpu_x2, fpu_y  out  5 each  to fpu x1/x2/y
- fpu_op  out  6  to fpu operation
- fpu_in_data  out  32  to fpu in_data
- fpu_ready  out  1  to fpu ready
- fpu_valid  in  1  from fpu valid
- fpu_out_data  in  32  from fpu out_data
- fpu_cond  in  1  from fpu cond
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_data  out  32  out_data captured at completion (meaningful for GET, FTOI)
- rsp_cond  out  1  cond captured after completion (meaningful for FCLT, FCZ)
- rsp_tag  out  4  tag of completed instruction
- rsp_err  out  1  opcode was illegal
- count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Legal opcodes: FADD 000000, FSUB 000001, FMUL 000010, FABS 000101, FMOV 000110, FNEG 010000, FCLT 100000, FCZ 101000, FTOI 111000, ITOF 111001, FORI 111101, SET 111110, GET 111111. All others are illegal.
- FIFO: push on req_valid && req_ready. Pop at the DRAIN→IDLE transition only. No bypass; a full FIFO gives req_ready=0 even when a pop occurs in the same cycle.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE→ISSUE when FIFO is non-empty, the head opcode is legal, and (!rsp_valid || rsp_ready).
- IDLE→DRAIN directly under the same response condition when the head opcode is illegal. fpu_ready stays 0 and rsp_err=1.
- ISSUE: fpu_ready=1; fpu_* outputs are driven from the FIFO head and stay constant. On the first cycle with fpu_valid=1, capture fpu_out_data into a data holding register and go to DRAIN. With fpu_valid=0, stay in ISSUE indefinitely; there is no timeout.
- DRAIN lasts exactly 1 cycle with fpu_ready=0.
  - It lets the fpu leave its write state, so a held ready cannot produce a second valid.
  - It is the cycle in which fpu_cond reflects the completed FCLT/FCZ; fpu_cond is sampled here.
  - At its end, load the rsp_* registers, set rsp_valid, pop the FIFO, and go to IDLE.
- rsp_cond is loaded from fpu_cond only for FCLT/FCZ; otherwise it keeps its previous value. rsp_data is 0 for illegal ops.
- rsp_valid clears on rsp_valid && rsp_ready unless it is reloaded in the same cycle; a reload wins.
- Outside ISSUE, the fpu_* operand outputs still show the FIFO head (0 when empty). Only fpu_ready gates the fpu.

## Timing
- Reset values: state IDLE; FIFO empty; count 0; req_ready 1; fpu_ready 0; rsp_valid 0; rsp_data, rsp_cond, rsp_tag, rsp_err 0; fpu_* 0. Reset mid-ISSUE aborts the instruction with no response. The fpu shares rstn.
- Push in cycle 0: IDLE sees it in cycle 1, ISSUE in cycle 2.
- Single-cycle ops (FMOV/FORI/SET/GET): fpu_valid in cycle 2, DRAIN in cycle 3, rsp_valid=1 from cycle 4.
- Multi-cycle ops: response 2 cycles after the fpu_valid cycle.
- Minimum issue spacing is 3 cycles (ISSUE, DRAIN, IDLE). The fpu never sees fpu_ready high on consecutive instructions without a low cycle between them.
- If the response is unconsumed, issue stalls in IDLE. The FIFO keeps accepting pushes until full.

## Test plan
- Reset, then push SET y=3 data=0x3F800000, tag=1 -> fpu_ready high only in cycle 2; rsp_valid in cycle 4 with tag=1 and err=0; count back to 0.
- SET r1=0x40000000, SET r2=0x3F800000, FCLT x1=2 x2=1 -> FCLT response has rsp_cond=1. Repeat with the operands swapped -> rsp_cond=0.
- SET r1=0x40490FDB, then FTOI x1=1 -> rsp_data=3. fpu_ready is low in the cycle after fpu_valid, and no duplicate valid occurs.
- Hold rsp_ready=0 and push 5 instructions with DEPTH=4 -> the first response is held, req_ready=0 at count=4, and no issue occurs. Release rsp_ready -> all 5 tags return in order.
- Push opcode 000111 with tag=9 between two GETs -> tag 9 responds with rsp_err=1 and rsp_data=0; fpu_ready is never asserted for it; the GETs complete normally.
- Assert rstn=0 during FMUL ISSUE -> the next cycle shows all outputs at reset values, and no response is produced for the FMUL.
